// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_byte_tx among NUM_REQ result sources. A round-robin arbiter
// picks one pending word, acknowledges it, and sends it as a byte frame:
// an optional ID header (8'hA0 | id) followed by the data bytes MSB-first,
// which is the byte order the host-side uart_data_tx uses.
//
// Ports
//   clk, reset     : system clock, synchronous active-high reset
//   req_valid[i]   : requester i has a word pending
//   req_data       : requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready[i]   : one-cycle pulse, word of requester i accepted
//   grant_id       : index of the requester currently being sent
//   busy           : high from the cycle after a grant until the frame ends
//   tx_data_byte   : byte to the transmitter, stable from tx_send_en to tx_done
//   tx_send_en     : one-cycle start pulse to uart_byte_tx.send_en
//   tx_done        : uart_byte_tx.tx_done, only looked at in ST_WAIT
//   frame_done     : one-cycle pulse after the last byte of a frame completes
//   err_timeout    : one-cycle pulse when a byte does not complete in time
//   state_dbg      : current FSM state (ST_* encoding below)
//
// Handshake: a requester raises req_valid[i] with req_data stable and keeps
// both stable until req_ready[i] pulses. The word is captured on the grant
// edge, so the requester may change req_data or drop req_valid in the same
// cycle req_ready[i] is seen. Dropping req_valid before the grant withdraws
// the request. Once acknowledged, a word is never re-sent, even on timeout.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int HEADER_EN  = 1,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [3:0]                    grant_id,
  output logic                          busy,
  output logic [7:0]                    tx_data_byte,
  output logic                          tx_send_en,
  input  logic                          tx_done,
  output logic                          frame_done,
  output logic                          err_timeout,
  output logic [2:0]                    state_dbg
);

  localparam int NBYTES = DATA_WIDTH / 8 + HEADER_EN;
  localparam int TO_W   = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [3:0]              rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [3:0]              bytes_left_q, bytes_left_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;

  logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
  logic [3:0]              grant_id_q, grant_id_d;
  logic                    busy_q, busy_d;
  logic [7:0]              tx_data_byte_q, tx_data_byte_d;
  logic                    tx_send_en_q, tx_send_en_d;
  logic                    frame_done_q, frame_done_d;
  logic                    err_timeout_q, err_timeout_d;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // Each requester's distance from the pointer is (i - ptr) mod NUM_REQ; the
  // valid requester with the smallest distance wins, which is the same as
  // scanning upward from the pointer and wrapping.
  // ---------------------------------------------------------------------------
  logic                    arb_found;
  logic [3:0]              arb_id;
  logic [3:0]              arb_next_ptr;
  logic [4:0]              arb_best_dist;
  logic [4:0]              arb_dist;
  logic [NUM_REQ-1:0]      arb_onehot;
  logic [DATA_WIDTH-1:0]   arb_word;
  logic [7:0]              arb_header;

  always_comb begin
    arb_found     = 1'b0;
    arb_id        = 4'd0;
    arb_best_dist = 5'(NUM_REQ);
    arb_dist      = 5'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (5'(i) >= {1'b0, rr_ptr_q}) begin
        arb_dist = 5'(i) - {1'b0, rr_ptr_q};
      end else begin
        arb_dist = 5'(i) + 5'(NUM_REQ) - {1'b0, rr_ptr_q};
      end
      if (req_valid[i] && (arb_dist < arb_best_dist)) begin
        arb_best_dist = arb_dist;
        arb_found     = 1'b1;
        arb_id        = 4'(i);
      end
    end
  end

  always_comb begin
    arb_onehot = '0;
    arb_word   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_id == 4'(i)) begin
        arb_onehot[i] = arb_found;
        arb_word      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign arb_next_ptr = (arb_id == 4'(NUM_REQ - 1)) ? 4'd0 : arb_id + 4'd1;
  assign arb_header   = {4'hA, arb_id};

  // ---------------------------------------------------------------------------
  // Frame FSM: next state and registered outputs
  // The shift register always holds the bytes still to be sent, MSB-first.
  // With a header the first byte is the header and the word is loaded
  // unshifted; without one the first data byte is sent straight away and the
  // word is loaded already shifted by one byte.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    shift_d        = shift_q;
    bytes_left_d   = bytes_left_q;
    to_cnt_d       = to_cnt_q;
    req_ready_d    = '0;
    grant_id_d     = grant_id_q;
    busy_d         = busy_q;
    tx_data_byte_d = tx_data_byte_q;
    tx_send_en_d   = 1'b0;
    frame_done_d   = 1'b0;
    err_timeout_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          state_d      = ST_SEND;
          rr_ptr_d     = arb_next_ptr;
          req_ready_d  = arb_onehot;
          grant_id_d   = arb_id;
          busy_d       = 1'b1;
          tx_send_en_d = 1'b1;
          bytes_left_d = 4'(NBYTES - 1);
          if (HEADER_EN != 0) begin
            tx_data_byte_d = arb_header;
            shift_d        = arb_word;
          end else begin
            tx_data_byte_d = arb_word[DATA_WIDTH-1 -: 8];
            shift_d        = arb_word << 8;
          end
        end
      end

      // tx_send_en is high during this cycle; a tx_done seen here belongs
      // to an earlier byte and is ignored.
      ST_SEND: begin
        state_d  = ST_WAIT;
        to_cnt_d = '0;
      end

      // to_cnt counts WAIT cycles without tx_done; the TIMEOUT-th such cycle
      // aborts the frame.
      ST_WAIT: begin
        if (tx_done) begin
          if (bytes_left_q == 4'd0) begin
            state_d      = ST_DONE;
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
          end else begin
            state_d        = ST_SEND;
            tx_send_en_d   = 1'b1;
            tx_data_byte_d = shift_q[DATA_WIDTH-1 -: 8];
            shift_d        = shift_q << 8;
            bytes_left_d   = bytes_left_q - 4'd1;
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d       = ST_ABORT;
          err_timeout_d = 1'b1;
          busy_d        = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_ABORT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= 4'd0;
      shift_q        <= '0;
      bytes_left_q   <= 4'd0;
      to_cnt_q       <= '0;
      req_ready_q    <= '0;
      grant_id_q     <= 4'd0;
      busy_q         <= 1'b0;
      tx_data_byte_q <= 8'h00;
      tx_send_en_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      shift_q        <= shift_d;
      bytes_left_q   <= bytes_left_d;
      to_cnt_q       <= to_cnt_d;
      req_ready_q    <= req_ready_d;
      grant_id_q     <= grant_id_d;
      busy_q         <= busy_d;
      tx_data_byte_q <= tx_data_byte_d;
      tx_send_en_q   <= tx_send_en_d;
      frame_done_q   <= frame_done_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign grant_id     = grant_id_q;
  assign busy         = busy_q;
  assign tx_data_byte = tx_data_byte_q;
  assign tx_send_en   = tx_send_en_q;
  assign frame_done   = frame_done_q;
  assign err_timeout  = err_timeout_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. Instance "a" is the 4-requester,
// 32-bit, header-enabled configuration with a short timeout; instance "b" is
// the header-less 8-bit configuration. The bench plays the byte transmitter:
// it watches tx_send_en and answers with a one-cycle tx_done after a chosen
// gap. Expected bytes are queued in exp_q from hand-written frames.
// All inputs change and all outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int TO  = 100;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ABORT = 3'd4;

  localparam logic [31:0] W0 = 32'h10203040;
  localparam logic [31:0] W1 = 32'h50607080;
  localparam logic [31:0] W2 = 32'h90A0B0C0;
  localparam logic [31:0] W3 = 32'hD0E0F001;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  // Instance a
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [3:0]       grant_id;
  logic             busy;
  logic [7:0]       tx_data_byte;
  logic             tx_send_en;
  logic             tx_done;
  logic             frame_done;
  logic             err_timeout;
  logic [2:0]       state_dbg;

  // Instance b
  logic [1:0]       b_req_valid;
  logic [15:0]      b_req_data;
  logic [1:0]       b_req_ready;
  logic [3:0]       b_grant_id;
  logic             b_busy;
  logic [7:0]       b_tx_data_byte;
  logic             b_tx_send_en;
  logic             b_tx_done;
  logic             b_frame_done;
  logic             b_err_timeout;
  logic [2:0]       b_state_dbg;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .HEADER_EN(1), .TIMEOUT(TO)
  ) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .grant_id(grant_id), .busy(busy), .tx_data_byte(tx_data_byte),
    .tx_send_en(tx_send_en), .tx_done(tx_done), .frame_done(frame_done),
    .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  uart_tx_arbiter #(
    .NUM_REQ(2), .DATA_WIDTH(8), .HEADER_EN(0), .TIMEOUT(TO)
  ) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_data(b_req_data), .req_ready(b_req_ready),
    .grant_id(b_grant_id), .busy(b_busy), .tx_data_byte(b_tx_data_byte),
    .tx_send_en(b_tx_send_en), .tx_done(b_tx_done), .frame_done(b_frame_done),
    .err_timeout(b_err_timeout), .state_dbg(b_state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [3:0] id, input logic [31:0] w);
    exp_q.push_back({4'hA, id});
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
  endtask

  task automatic chk_reset_state();
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_grant_id", grant_id, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_data_byte", tx_data_byte, 8'h00);
    chk("rst_tx_send_en", tx_send_en, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_err_timeout", err_timeout, 1'b0);
    chk("rst_state", state_dbg, S_IDLE);
  endtask

  // Wait (bounded) for a frame's first tx_send_en, then serve all five bytes.
  // Ends on the cycle after frame_done (state back in IDLE).
  task automatic serve_frame(input int gap, input logic [3:0] exp_ready,
                             input logic [3:0] exp_gid, input bit drop);
    int budget;
    logic [7:0] e;
    budget = 0;
    while (tx_send_en !== 1'b1 && budget < 64) begin
      @(negedge clk);
      budget++;
    end
    chk("first_send_en", tx_send_en, 1'b1);
    chk("req_ready_pulse", req_ready, exp_ready);
    chk("busy_in_frame", busy, 1'b1);
    chk("grant_id", grant_id, exp_gid);
    if (drop) req_valid = req_valid & ~exp_ready;
    for (int b = 0; b < 5; b++) begin
      if (b > 0) chk("next_send_en", tx_send_en, 1'b1);
      e = 8'hxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk("tx_byte", tx_data_byte, e);
      @(negedge clk);
      chk("send_en_one_cycle", tx_send_en, 1'b0);
      if (b == 0) chk("req_ready_one_cycle", req_ready, 4'b0000);
      repeat (gap - 1) @(negedge clk);
      chk("byte_stable", tx_data_byte, e);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
    chk("frame_done_pulse", frame_done, 1'b1);
    chk("busy_after_frame", busy, 1'b0);
    chk("no_err_timeout", err_timeout, 1'b0);
    @(negedge clk);
    chk("frame_done_one_cycle", frame_done, 1'b0);
    chk("state_idle_after_frame", state_dbg, S_IDLE);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int budget;
    reset       = 1'b1;
    req_valid   = '0;
    req_data    = '0;
    tx_done     = 1'b0;
    b_req_valid = '0;
    b_req_data  = '0;
    b_tx_done   = 1'b0;

    // Reset values, then a stale tx_done right after reset release.
    repeat (3) @(negedge clk);
    chk_reset_state();
    chk("b_rst_busy", b_busy, 1'b0);
    chk("b_rst_send_en", b_tx_send_en, 1'b0);
    reset   = 1'b0;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("stale_done_state", state_dbg, S_IDLE);
    chk("stale_done_send_en", tx_send_en, 1'b0);

    // Single frame from requester 1: A1 11 22 33 44.
    req_data  = {W3, W2, 32'h11223344, W0};
    req_valid = 4'b0010;
    push_frame(4'd1, 32'h11223344);
    serve_frame(3, 4'b0010, 4'd1, 1'b1);

    // Timeout: requester 3 (pointer is 2). tx_done coincident with the
    // first tx_send_en must be ignored, so the abort lands at S+101.
    req_data  = {32'hCAFEF00D, W2, W1, W0};
    req_valid = 4'b1000;
    budget = 0;
    while (tx_send_en !== 1'b1 && budget < 64) begin
      @(negedge clk);
      budget++;
    end
    chk("to_send_en", tx_send_en, 1'b1);
    chk("to_header", tx_data_byte, 8'hA3);
    chk("to_req_ready", req_ready, 4'b1000);
    req_valid = '0;
    tx_done   = 1'b1;
    @(negedge clk);
    tx_done   = 1'b0;
    repeat (TO - 1) @(negedge clk);
    chk("to_err_before", err_timeout, 1'b0);
    chk("to_busy_before", busy, 1'b1);
    chk("to_state_wait", state_dbg, S_WAIT);
    @(negedge clk);
    chk("to_err_pulse", err_timeout, 1'b1);
    chk("to_busy_cleared", busy, 1'b0);
    chk("to_no_frame_done", frame_done, 1'b0);
    chk("to_state_abort", state_dbg, S_ABORT);
    @(negedge clk);
    chk("to_err_one_cycle", err_timeout, 1'b0);
    chk("to_state_idle", state_dbg, S_IDLE);

    // Fairness: requesters 0 and 2 held valid, pointer at 0.
    req_data  = {W3, 32'h01020304, W1, 32'hDEADBEEF};
    req_valid = 4'b0101;
    push_frame(4'd0, 32'hDEADBEEF);
    serve_frame(1, 4'b0001, 4'd0, 1'b0);
    push_frame(4'd2, 32'h01020304);
    serve_frame(2, 4'b0100, 4'd2, 1'b0);
    push_frame(4'd0, 32'hDEADBEEF);
    serve_frame(1, 4'b0001, 4'd0, 1'b0);
    push_frame(4'd2, 32'h01020304);
    serve_frame(1, 4'b0100, 4'd2, 1'b0);
    req_valid = '0;

    // All requesters valid after reset: A0 A1 A2 A3 A0.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_data  = {W3, W2, W1, W0};
    req_valid = 4'b1111;
    push_frame(4'd0, W0);
    serve_frame(1, 4'b0001, 4'd0, 1'b0);
    push_frame(4'd1, W1);
    serve_frame(2, 4'b0010, 4'd1, 1'b0);
    push_frame(4'd2, W2);
    serve_frame(1, 4'b0100, 4'd2, 1'b0);
    push_frame(4'd3, W3);
    serve_frame(3, 4'b1000, 4'd3, 1'b0);
    push_frame(4'd0, W0);
    serve_frame(1, 4'b0001, 4'd0, 1'b0);
    req_valid = '0;

    // Reset mid-frame: requester 2 (pointer 1), reset after 2nd byte done.
    req_valid = 4'b0100;
    budget = 0;
    while (tx_send_en !== 1'b1 && budget < 64) begin
      @(negedge clk);
      budget++;
    end
    chk("mid_header", tx_data_byte, 8'hA2);
    chk("mid_grant_id", grant_id, 4'd2);
    req_valid = '0;
    repeat (2) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("mid_send_en_b1", tx_send_en, 1'b1);
    chk("mid_byte_b1", tx_data_byte, 8'h90);
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("mid_send_en_b2", tx_send_en, 1'b1);
    chk("mid_byte_b2", tx_data_byte, 8'hA0);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state();
    reset   = 1'b0;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("mid_stale_state", state_dbg, S_IDLE);
    chk("mid_stale_send_en", tx_send_en, 1'b0);
    chk("mid_stale_frame_done", frame_done, 1'b0);
    req_valid = 4'b0001;
    push_frame(4'd0, W0);
    serve_frame(2, 4'b0001, 4'd0, 1'b1);

    // No header, 8-bit word: one byte 5A, frame_done the cycle after tx_done.
    b_req_data  = {8'h00, 8'h5A};
    b_req_valid = 2'b01;
    @(negedge clk);
    chk("b_send_en", b_tx_send_en, 1'b1);
    chk("b_byte", b_tx_data_byte, 8'h5A);
    chk("b_req_ready", b_req_ready, 2'b01);
    b_req_valid = '0;
    repeat (2) @(negedge clk);
    chk("b_no_send_en", b_tx_send_en, 1'b0);
    b_tx_done = 1'b1;
    @(negedge clk);
    b_tx_done = 1'b0;
    chk("b_frame_done", b_frame_done, 1'b1);
    chk("b_busy_cleared", b_busy, 1'b0);
    chk("b_no_second_byte", b_tx_send_en, 1'b0);
    @(negedge clk);
    chk("b_frame_done_one_cycle", b_frame_done, 1'b0);
    chk("b_state_idle", b_state_dbg, S_IDLE);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
